// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// feeding a first-word-fall-through receive FIFO with a valid/ready pop side.
// The serial input is double-synchronized; every bit is sampled at mid-bit.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit check).
module uart_rx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] MID_CNT  = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] END_CNT  = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;
`endif

  // Even parity bit for a data byte: makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  logic [1:0]    sync_r;
  logic          rx_s;
  state_t        state_r, state_nxt;
  logic [CW-1:0] cnt_r, cnt_nxt;
  logic [2:0]    bit_r, bit_nxt;
  logic [7:0]    shift_r, shift_nxt;
  logic          commit_r, commit_nxt;
  logic          frame_err_r, frame_err_nxt;
`ifdef UART_RX_PARITY_EN
  logic          par_ok_r, par_ok_nxt;
  logic          parity_err_r, parity_err_nxt;
`endif

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_r, rd_ptr_r;
  logic          overrun_r;
  logic          full_s, pop_s, push_s;

  assign rx_s = sync_r[1];

  // Two-flop synchronizer for the asynchronous serial line, preset to idle-high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], uart_rx};
    end
  end

  // Receiver next-state logic: bit timing, shifting, framing and parity decisions.
  always_comb begin
    state_nxt      = state_r;
    cnt_nxt        = cnt_r;
    bit_nxt        = bit_r;
    shift_nxt      = shift_r;
    commit_nxt     = 1'b0;
    frame_err_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ok_nxt     = par_ok_r;
    parity_err_nxt = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt = ST_START;
          cnt_nxt   = '0;
          bit_nxt   = 3'd0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == MID_CNT) begin
          cnt_nxt = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          if (rx_s) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DATA;
          end
        end else begin
          cnt_nxt = cnt_r + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_r == END_CNT) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_s, shift_r[7:1]};
          bit_nxt   = bit_r + 3'd1;
          if (bit_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end else begin
            state_nxt = ST_DATA;
          end
        end else begin
          cnt_nxt = cnt_r + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_r == END_CNT) begin
          cnt_nxt    = '0;
          par_ok_nxt = (rx_s == even_parity(shift_r));
          state_nxt  = ST_STOP;
        end else begin
          cnt_nxt = cnt_r + CW'(1);
        end
      end
`endif
      ST_STOP: begin
        if (cnt_r == END_CNT) begin
          cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
          parity_err_nxt = !par_ok_r;
`endif
          // Leaving at mid-stop lets the next start edge be caught without loss.
          if (rx_s) begin
            state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            commit_nxt = par_ok_r;
`else
            commit_nxt = 1'b1;
`endif
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = ST_WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt_r + CW'(1);
        end
      end
      ST_WAIT_IDLE: begin
        // Break condition: ignore the line until it returns high.
        if (rx_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        bit_nxt   = 3'd0;
      end
    endcase
  end

  // Receiver state register; reset discards any partially received byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      bit_r        <= 3'd0;
      shift_r      <= 8'h00;
      commit_r     <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_r     <= 1'b1;
      parity_err_r <= 1'b0;
`endif
    end else begin
      state_r      <= state_nxt;
      cnt_r        <= cnt_nxt;
      bit_r        <= bit_nxt;
      shift_r      <= shift_nxt;
      commit_r     <= commit_nxt;
      frame_err_r  <= frame_err_nxt;
`ifdef UART_RX_PARITY_EN
      par_ok_r     <= par_ok_nxt;
      parity_err_r <= parity_err_nxt;
`endif
    end
  end

  assign rx_count = wr_ptr_r - rd_ptr_r;
  assign full_s   = (rx_count == FULL_CNT);
  assign rx_valid = (rx_count != '0);
  assign pop_s    = rx_valid & rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_s   = commit_r & (~full_s | pop_s);
  assign rx_data  = mem_r[rd_ptr_r[AW-1:0]];

  // FIFO storage and pointers; overrun flags a committed byte that had no room.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      overrun_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
        wr_ptr_r                <= wr_ptr_r + (AW + 1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
      end
      overrun_r <= commit_r & full_s & ~pop_s;
    end
  end

  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (CLK_DIV=16, FIFO_DEPTH=4).
// Parity scenarios are compiled in only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;

  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] rx_count;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int fe_cnt       = 0;
  int ov_cnt       = 0;
  int pe_cnt       = 0;

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_count   (rx_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle each error pulse is high, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_err)  fe_cnt <= fe_cnt + 1;
    if (overrun)    ov_cnt <= ov_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, tests_failed=%0d", tests_failed);
    $fatal(1);
  end

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CLK_DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic with_par, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (with_par) drive_bit(par_bit);
    drive_bit(stop_bit);
    uart_rx = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    rst_n    = 1'b0;
    idle_cycles(3);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    tests_run++;
    if (rx_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", rx_count); end
    tests_run++;
    if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    tests_run++;
    if ({frame_err, overrun, parity_err} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_pulses: got %b expected 000", {frame_err, overrun, parity_err});
    end
    idle_cycles(1);
  endtask

  task automatic test_basic();
    int fe0, ov0, pe0;
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    @(negedge clk);
    tests_run++;
    if (rx_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %b expected 1", rx_valid); end
    tests_run++;
    if (rx_data !== 8'hA5) begin tests_failed++; $display("FAIL basic_data: got %h expected a5", rx_data); end
    tests_run++;
    if (rx_count !== 3'd1) begin tests_failed++; $display("FAIL basic_count: got %0d expected 1", rx_count); end
    tests_run++;
    if ((fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0) != 0) begin
      tests_failed++;
      $display("FAIL basic_no_errors: got fe=%0d ov=%0d pe=%0d expected 0 0 0",
               fe_cnt - fe0, ov_cnt - ov0, pe_cnt - pe0);
    end
    idle_cycles(1);
    pop_one();
    @(negedge clk);
    tests_run++;
    if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_pop_empty: got %b expected 0", rx_valid); end
    idle_cycles(1);
  endtask

  // A low pulse shorter than half a bit must be rejected at the start-bit check.
  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    uart_rx = 1'b0;
    idle_cycles(6);
    uart_rx = 1'b1;
    idle_cycles(12 * CLK_DIV);
    @(negedge clk);
    tests_run++;
    if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL glitch_valid: got %b expected 0", rx_valid); end
    tests_run++;
    if (fe_cnt - fe0 != 0) begin tests_failed++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cnt - fe0); end
    idle_cycles(1);
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle_cycles(2 * CLK_DIV);
    @(negedge clk);
    tests_run++;
    if (fe_cnt - fe0 != 1) begin tests_failed++; $display("FAIL frame_err_pulse: got %0d expected 1", fe_cnt - fe0); end
    tests_run++;
    if (rx_count !== 3'd0) begin tests_failed++; $display("FAIL frame_err_count: got %0d expected 0", rx_count); end
    idle_cycles(1);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    @(negedge clk);
    tests_run++;
    if (rx_data !== 8'h81 || rx_count !== 3'd1) begin
      tests_failed++; $display("FAIL frame_err_next: got data=%h count=%0d expected 81 1", rx_data, rx_count);
    end
    idle_cycles(1);
    pop_one();
  endtask

  task automatic test_back_to_back();
    int ov0, fe0;
    ov0 = ov_cnt; fe0 = fe_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    @(negedge clk);
    tests_run++;
    if (rx_count !== 3'd4) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 4", rx_count); end
    tests_run++;
    if (ov_cnt - ov0 != 1) begin tests_failed++; $display("FAIL b2b_overrun: got %0d expected 1", ov_cnt - ov0); end
    tests_run++;
    if (fe_cnt - fe0 != 0) begin tests_failed++; $display("FAIL b2b_frame_err: got %0d expected 0", fe_cnt - fe0); end
    idle_cycles(1);
    rx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (rx_valid !== 1'b1 || rx_data !== 8'(i)) begin
        tests_failed++; $display("FAIL b2b_pop%0d: got valid=%b data=%h expected 1 %h", i, rx_valid, rx_data, 8'(i));
      end
    end
    @(negedge clk);
    tests_run++;
    if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drained: got %b expected 0", rx_valid); end
    rx_ready = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_reset_mid_frame();
    int fe0;
    send_frame(8'h99, 1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    // Start 0x55 and abort it with a one-clock reset during the data bits.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    uart_rx = 1'b0;
    idle_cycles(5);
    uart_rx = 1'b1;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (rx_count !== 3'd0 || rx_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_fifo: got count=%0d valid=%b expected 0 0", rx_count, rx_valid);
    end
    tests_run++;
    if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL rstmid_data: got %h expected 00", rx_data); end
    fe0 = fe_cnt;
    idle_cycles(2 * CLK_DIV);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    @(negedge clk);
    tests_run++;
    if (rx_data !== 8'h7E || rx_count !== 3'd1) begin
      tests_failed++; $display("FAIL rstmid_next: got data=%h count=%0d expected 7e 1", rx_data, rx_count);
    end
    tests_run++;
    if (fe_cnt - fe0 != 0) begin tests_failed++; $display("FAIL rstmid_frame_err: got %0d expected 0", fe_cnt - fe0); end
    idle_cycles(1);
    pop_one();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pe0;
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    idle_cycles(4);
    @(negedge clk);
    tests_run++;
    if (pe_cnt - pe0 != 1) begin tests_failed++; $display("FAIL parity_bad_pulse: got %0d expected 1", pe_cnt - pe0); end
    tests_run++;
    if (rx_count !== 3'd0) begin tests_failed++; $display("FAIL parity_bad_drop: got %0d expected 0", rx_count); end
    pe0 = pe_cnt;
    idle_cycles(1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    idle_cycles(4);
    @(negedge clk);
    tests_run++;
    if (rx_data !== 8'h07 || rx_count !== 3'd1) begin
      tests_failed++; $display("FAIL parity_good: got data=%h count=%0d expected 07 1", rx_data, rx_count);
    end
    tests_run++;
    if (pe_cnt - pe0 != 0) begin tests_failed++; $display("FAIL parity_good_pulse: got %0d expected 0", pe_cnt - pe0); end
    idle_cycles(1);
    pop_one();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
